// File: rtl/proc_pkg.sv
// Shared types for proc_core: opcodes, FSM states, flag bit positions and instruction field layout.
package proc_pkg;

   typedef enum logic [4:0] {
      OP_ADD  = 5'd0,
      OP_SUB  = 5'd1,
      OP_MUL  = 5'd2,
      OP_DIV  = 5'd3,
      OP_MOD  = 5'd4,
      OP_AND  = 5'd5,
      OP_OR   = 5'd6,
      OP_XOR  = 5'd7,
      OP_GT   = 5'd8,
      OP_LT   = 5'd9,
      OP_EQ   = 5'd10,
      OP_NE   = 5'd11,
      OP_MOV  = 5'd12,
      OP_SHL  = 5'd13,
      OP_SHR  = 5'd14,
      OP_LDI  = 5'd15,
      OP_IN   = 5'd16,
      OP_OUT  = 5'd17,
      OP_HALT = 5'd18
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXEC,
      ST_IO_IN,
      ST_IO_OUT,
      ST_HALT
   } state_e;

   localparam int FLG_Z = 0;
   localparam int FLG_C = 1;
   localparam int FLG_S = 2;
   localparam int FLG_P = 3;
   localparam int FLG_V = 4;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 11;
   localparam int RD_MSB  = 10;
   localparam int RD_LSB  = 8;
   localparam int RS_MSB  = 7;
   localparam int RS_LSB  = 5;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;
   localparam int REG_AW  = 3;

endpackage

// File: rtl/proc_if.sv
// Handshake bundle between proc_core and its instruction source / IO peripherals.
// master = source side (testbench, sequencer), slave = core side.
interface proc_if #(
   parameter int DATA_W = 8
);
   logic [15:0]       instr;
   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] io_in;
   logic              io_in_valid;
   logic              io_in_ready;
   logic [DATA_W-1:0] io_out;
   logic              io_out_valid;
   logic              io_out_ready;
   logic [DATA_W-1:0] result;
   logic [4:0]        flags;
   logic              halted;

   modport master (
      output instr, instr_valid, io_in, io_in_valid, io_out_ready,
      input  instr_ready, io_in_ready, io_out, io_out_valid, result, flags, halted
   );

   modport slave (
      input  instr, instr_valid, io_in, io_in_valid, io_out_ready,
      output instr_ready, io_in_ready, io_out, io_out_valid, result, flags, halted
   );
endinterface

// File: rtl/proc_regfile.sv
// Register file: two combinational read ports, one synchronous write port, synchronous clear on rst.
module proc_regfile
   import proc_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NREGS  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rd_a_addr,
   input  logic [REG_AW-1:0] rd_b_addr,
   output logic [DATA_W-1:0] rd_a_dat,
   output logic [DATA_W-1:0] rd_b_dat,
   input  logic              wr_vld,
   input  logic [REG_AW-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_dat
);
   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];

   assign rd_a_dat = regs_q[rd_a_addr];
   assign rd_b_dat = regs_q[rd_b_addr];

   always_comb begin
      regs_d = regs_q;
      if (wr_vld) regs_d[wr_addr] = wr_dat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end
endmodule

// File: rtl/proc_core.sv
// Multi-cycle execute core: ALU ops retire one edge after acceptance; IN/OUT stall until handshake.
// MUL/DIV/MOD exist only when PROC_MULDIV_EN is defined, otherwise opcodes 2-4 act as NOP.
module proc_core
   import proc_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NREGS  = 8
) (
   input  logic  clk,
   input  logic  rst,
   proc_if.slave bus
);
   if (NREGS != 8) begin : g_nregs_chk
      $error("proc_core: NREGS must be 8");
   end
   if (DATA_W < 8) begin : g_width_chk
      $error("proc_core: DATA_W must be at least 8");
   end

   state_e            state_q, state_d;
   logic [15:0]       instr_q, instr_d;
   logic              instr_ready_q, instr_ready_d;
   logic              io_in_ready_q, io_in_ready_d;
   logic              io_out_valid_q, io_out_valid_d;
   logic [DATA_W-1:0] io_out_q, io_out_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [4:0]        flags_q, flags_d;
   logic              halted_q, halted_d;

   op_e               op;
   logic [REG_AW-1:0] rd_idx, rs_idx;
   logic [DATA_W-1:0] opa, opb, alu_res, wr_dat;
   logic              alu_c, alu_v, alu_wr, wr_vld;

   assign op     = op_e'(instr_q[OP_MSB:OP_LSB]);
   assign rd_idx = instr_q[RD_MSB:RD_LSB];
   assign rs_idx = instr_q[RS_MSB:RS_LSB];

   proc_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .rd_a_addr (rd_idx),
      .rd_b_addr (rs_idx),
      .rd_a_dat  (opa),
      .rd_b_dat  (opb),
      .wr_vld    (wr_vld),
      .wr_addr   (rd_idx),
      .wr_dat    (wr_dat)
   );

   function automatic logic [4:0] mk_flags(input logic [DATA_W-1:0] res, input logic c,
                                           input logic v);
      logic [4:0] f;
      f        = '0;
      f[FLG_Z] = (res == '0);
      f[FLG_C] = c;
      f[FLG_S] = res[DATA_W-1];
      f[FLG_P] = ~^res;
      f[FLG_V] = v;
      return f;
   endfunction

`ifdef PROC_MULDIV_EN
   logic [2*DATA_W-1:0] prod;
   assign prod = (2*DATA_W)'(opa) * (2*DATA_W)'(opb);
`endif

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_wr  = 1'b1;
      case (op)
         OP_ADD: begin
            {alu_c, alu_res} = {1'b0, opa} + {1'b0, opb};
            alu_v = (opa[DATA_W-1] == opb[DATA_W-1]) && (alu_res[DATA_W-1] != opa[DATA_W-1]);
         end
         OP_SUB: begin
            alu_res = opa - opb;
            alu_c   = (opa < opb);
            alu_v   = (opa[DATA_W-1] != opb[DATA_W-1]) && (alu_res[DATA_W-1] != opa[DATA_W-1]);
         end
`ifdef PROC_MULDIV_EN
         OP_MUL: begin
            alu_res = prod[DATA_W-1:0];
            alu_c   = |prod[2*DATA_W-1:DATA_W];
         end
         OP_DIV: begin
            alu_c   = (opb == '0);
            alu_res = alu_c ? '1 : opa / opb;
         end
         OP_MOD: begin
            alu_c   = (opb == '0);
            alu_res = alu_c ? opa : opa % opb;
         end
`endif
         OP_AND:  alu_res = opa & opb;
         OP_OR:   alu_res = opa | opb;
         OP_XOR:  alu_res = opa ^ opb;
         OP_GT:   alu_res = DATA_W'(opa > opb);
         OP_LT:   alu_res = DATA_W'(opa < opb);
         OP_EQ:   alu_res = DATA_W'(opa == opb);
         OP_NE:   alu_res = DATA_W'(opa != opb);
         OP_MOV:  alu_res = opb;
         OP_SHL:  {alu_c, alu_res} = {opa, 1'b0};
         OP_SHR:  {alu_res, alu_c} = {1'b0, opa};
         OP_LDI:  alu_res = DATA_W'(instr_q[IMM_MSB:IMM_LSB]);
         default: alu_wr = 1'b0;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      instr_d        = instr_q;
      instr_ready_d  = instr_ready_q;
      io_in_ready_d  = io_in_ready_q;
      io_out_valid_d = io_out_valid_q;
      io_out_d       = io_out_q;
      result_d       = result_q;
      flags_d        = flags_q;
      halted_d       = halted_q;
      wr_vld         = 1'b0;
      wr_dat         = alu_res;
      case (state_q)
         ST_IDLE: begin
            if (bus.instr_valid && instr_ready_q) begin
               instr_d       = bus.instr;
               instr_ready_d = 1'b0;
               if (op_e'(bus.instr[OP_MSB:OP_LSB]) == OP_HALT) begin
                  state_d  = ST_HALT;
                  halted_d = 1'b1;
               end else begin
                  state_d = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            // IN/OUT park in their IO state; everything else retires here
            if (op == OP_IN) begin
               state_d       = ST_IO_IN;
               io_in_ready_d = 1'b1;
            end else if (op == OP_OUT) begin
               state_d        = ST_IO_OUT;
               io_out_d       = opa;
               io_out_valid_d = 1'b1;
            end else begin
               state_d       = ST_IDLE;
               instr_ready_d = 1'b1;
               if (alu_wr) begin
                  wr_vld   = 1'b1;
                  result_d = alu_res;
                  flags_d  = mk_flags(alu_res, alu_c, alu_v);
               end
            end
         end
         ST_IO_IN: begin
            if (bus.io_in_valid) begin
               wr_vld        = 1'b1;
               wr_dat        = bus.io_in;
               result_d      = bus.io_in;
               flags_d       = mk_flags(bus.io_in, 1'b0, 1'b0);
               io_in_ready_d = 1'b0;
               instr_ready_d = 1'b1;
               state_d       = ST_IDLE;
            end
         end
         ST_IO_OUT: begin
            if (bus.io_out_ready) begin
               io_out_valid_d = 1'b0;
               instr_ready_d  = 1'b1;
               state_d        = ST_IDLE;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         instr_q        <= '0;
         instr_ready_q  <= 1'b1;
         io_in_ready_q  <= 1'b0;
         io_out_valid_q <= 1'b0;
         io_out_q       <= '0;
         result_q       <= '0;
         flags_q        <= '0;
         halted_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         instr_q        <= instr_d;
         instr_ready_q  <= instr_ready_d;
         io_in_ready_q  <= io_in_ready_d;
         io_out_valid_q <= io_out_valid_d;
         io_out_q       <= io_out_d;
         result_q       <= result_d;
         flags_q        <= flags_d;
         halted_q       <= halted_d;
      end
   end

   assign bus.instr_ready  = instr_ready_q;
   assign bus.io_in_ready  = io_in_ready_q;
   assign bus.io_out_valid = io_out_valid_q;
   assign bus.io_out       = io_out_q;
   assign bus.result       = result_q;
   assign bus.flags        = flags_q;
   assign bus.halted       = halted_q;
endmodule
